// File: rtl/loadupdownmodcount.sv
// Load/up/down counter over 0..lim with wrap or saturate, sync clear, tc pulse and sticky ovf.
// Optional compare output enabled by defining LOADUPDOWNMODCOUNT_CMP_EN (adds cmp/match).
module loadupdownmodcount #(
    parameter int unsigned N = 4
) (
    input  logic         ck,
    input  logic         rn,
    input  logic         clr,
    input  logic         load,
    input  logic [N-1:0] val,
    input  logic         en,
    input  logic         up,
    input  logic         sat,
    input  logic [N-1:0] lim,
    input  logic         ovf_clr,
    output logic [N-1:0] cnt,
    output logic         tc,
    output logic         ovf
`ifdef LOADUPDOWNMODCOUNT_CMP_EN
    ,
    input  logic [N-1:0] cmp,
    output logic         match
`endif
);

    logic [N-1:0] cnt_nxt;
    logic         boundary;
    logic         at_top;
    logic         at_zero;
    logic         ovf_nxt;

    assign at_top  = (cnt >= lim);
    assign at_zero = (cnt == '0);

    // A count above a lowered lim counts down normally; only cnt==0 is a low boundary.
    always_comb begin
        cnt_nxt  = cnt;
        boundary = 1'b0;
        if (clr) begin
            cnt_nxt = '0;
        end else if (load) begin
            cnt_nxt = (val > lim) ? lim : val;
        end else if (en) begin
            if (up) begin
                if (at_top) begin
                    boundary = 1'b1;
                    cnt_nxt  = sat ? lim : '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end else begin
                if (at_zero) begin
                    boundary = 1'b1;
                    cnt_nxt  = sat ? '0 : lim;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
        end
    end

    always_comb begin
        ovf_nxt = ovf;
        if (clr)
            ovf_nxt = 1'b0;
        else if (boundary)
            ovf_nxt = 1'b1;
        else if (ovf_clr)
            ovf_nxt = 1'b0;
    end

    always_ff @(posedge ck or negedge rn) begin
        if (!rn) begin
            cnt <= '0;
            tc  <= 1'b0;
            ovf <= 1'b0;
        end else begin
            cnt <= cnt_nxt;
            tc  <= boundary;
            ovf <= ovf_nxt;
        end
    end

`ifdef LOADUPDOWNMODCOUNT_CMP_EN
    // Compare against the next count so match lines up with the registered cnt.
    always_ff @(posedge ck or negedge rn) begin
        if (!rn)
            match <= 1'b0;
        else
            match <= (cnt_nxt == cmp);
    end
`endif

endmodule

// File: tb/tb_loadupdownmodcount.sv
// Scoreboard bench for loadupdownmodcount; define LOADUPDOWNMODCOUNT_CMP_EN to also cover cmp/match.
module tb_loadupdownmodcount;

    localparam int unsigned N = 4;

    logic         ck;
    logic         rn;
    logic         clr;
    logic         load;
    logic [N-1:0] val;
    logic         en;
    logic         up;
    logic         sat;
    logic [N-1:0] lim;
    logic         ovf_clr;
    logic [N-1:0] cnt;
    logic         tc;
    logic         ovf;
`ifdef LOADUPDOWNMODCOUNT_CMP_EN
    logic [N-1:0] cmp;
    logic         match;
`endif

    loadupdownmodcount #(.N(N)) dut (
        .ck      (ck),
        .rn      (rn),
        .clr     (clr),
        .load    (load),
        .val     (val),
        .en      (en),
        .up      (up),
        .sat     (sat),
        .lim     (lim),
        .ovf_clr (ovf_clr),
        .cnt     (cnt),
        .tc      (tc),
        .ovf     (ovf)
`ifdef LOADUPDOWNMODCOUNT_CMP_EN
        ,
        .cmp     (cmp),
        .match   (match)
`endif
    );

    initial ck = 1'b0;
    always #5 ck = ~ck;

    typedef struct {
        logic [N-1:0] cnt;
        logic         tc;
        logic         ovf;
        logic         match;
    } exp_t;

    exp_t sb[$];

    int n_chk  = 0;
    int n_fail = 0;

    logic [N-1:0] m_cnt;
    logic         m_tc;
    logic         m_ovf;
    logic         m_match;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model of one clock edge, then compare after the edge.
    task automatic tick(input string tag);
        exp_t         e;
        logic [N-1:0] nc;
        logic         ev;
        nc = m_cnt;
        ev = 1'b0;
        if (clr) begin
            nc = '0;
        end else if (load) begin
            nc = (val > lim) ? lim : val;
        end else if (en && up) begin
            if (m_cnt < lim) nc = m_cnt + 1'b1;
            else begin ev = 1'b1; nc = sat ? lim : '0; end
        end else if (en && !up) begin
            if (m_cnt == '0) begin ev = 1'b1; nc = sat ? '0 : lim; end
            else nc = m_cnt - 1'b1;
        end
        m_cnt = nc;
        m_tc  = ev;
        if (clr) m_ovf = 1'b0;
        else if (ev) m_ovf = 1'b1;
        else if (ovf_clr) m_ovf = 1'b0;
`ifdef LOADUPDOWNMODCOUNT_CMP_EN
        m_match = (nc == cmp);
`else
        m_match = 1'b0;
`endif
        e.cnt = m_cnt; e.tc = m_tc; e.ovf = m_ovf; e.match = m_match;
        sb.push_back(e);
        @(posedge ck);
        #1;
        if (sb.size() == 0) begin
            check_val({tag, ".sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check_val({tag, ".cnt"}, 32'(cnt), 32'(e.cnt));
            check_val({tag, ".tc"},  32'(tc),  32'(e.tc));
            check_val({tag, ".ovf"}, 32'(ovf), 32'(e.ovf));
`ifdef LOADUPDOWNMODCOUNT_CMP_EN
            check_val({tag, ".match"}, 32'(match), 32'(e.match));
`endif
        end
    endtask

    task automatic idle_inputs();
        clr = 1'b0; load = 1'b0; en = 1'b0; ovf_clr = 1'b0;
    endtask

    initial begin
        rn = 1'b0; clr = 1'b0; load = 1'b0; val = '0; en = 1'b0;
        up = 1'b1; sat = 1'b0; lim = '0; ovf_clr = 1'b0;
`ifdef LOADUPDOWNMODCOUNT_CMP_EN
        cmp = '0;
`endif
        m_cnt = '0; m_tc = 1'b0; m_ovf = 1'b0; m_match = 1'b0;
        #3;
        check_val("reset.cnt", 32'(cnt), 32'd0);
        check_val("reset.tc",  32'(tc),  32'd0);
        check_val("reset.ovf", 32'(ovf), 32'd0);
`ifdef LOADUPDOWNMODCOUNT_CMP_EN
        check_val("reset.match", 32'(match), 32'd0);
`endif
        @(posedge ck); #1;
        rn = 1'b1;

        // Wrap-mode up count, lim=5
        lim = 4'd5; sat = 1'b0; up = 1'b1; en = 1'b1;
        for (int i = 0; i < 12; i++) tick("wrap_up");
        check_val("wrap_up.final_cnt", 32'(cnt), 32'd0);

        // Saturating down count from load 3
        idle_inputs(); clr = 1'b1; tick("clr1");
        idle_inputs(); sat = 1'b1; load = 1'b1; val = 4'd3; tick("load3");
        idle_inputs(); en = 1'b1; up = 1'b0;
        for (int i = 0; i < 5; i++) tick("sat_down");
        check_val("sat_down.tc_held", 32'(tc), 32'd1);
        ovf_clr = 1'b1; tick("ovfclr_vs_event");
        check_val("ovfclr_vs_event.ovf", 32'(ovf), 32'd1);
        en = 1'b0; tick("ovfclr_alone");

        // Load clamped to lim, clr beats load
        idle_inputs(); lim = 4'd9; load = 1'b1; val = 4'd12; tick("load_clamp");
        check_val("load_clamp.abs", 32'(cnt), 32'd9);
        en = 1'b1; up = 1'b1; sat = 1'b0; load = 1'b0; tick("wrap_ovf");
        clr = 1'b1; load = 1'b1; tick("clr_over_load");

        // Lim lowered below the count
        idle_inputs(); lim = 4'd9; load = 1'b1; val = 4'd8; tick("load8a");
        idle_inputs(); lim = 4'd3; en = 1'b1; up = 1'b1; sat = 1'b0; tick("above_lim_up");
        check_val("above_lim_up.abs", 32'(cnt), 32'd0);
        idle_inputs(); lim = 4'd9; load = 1'b1; val = 4'd8; tick("load8b");
        idle_inputs(); lim = 4'd3; en = 1'b1; up = 1'b0; tick("above_lim_down");
        check_val("above_lim_down.abs", 32'(cnt), 32'd7);

        // lim=0: every enabled step is an event
        idle_inputs(); lim = '0; en = 1'b1; up = 1'b1; sat = 1'b1;
        for (int i = 0; i < 3; i++) tick("lim0_up");
        up = 1'b0; sat = 1'b0;
        for (int i = 0; i < 3; i++) tick("lim0_down");

        // Asynchronous reset between edges
        #2;
        rn = 1'b0;
        #1;
        check_val("async_rst.cnt", 32'(cnt), 32'd0);
        check_val("async_rst.tc",  32'(tc),  32'd0);
        check_val("async_rst.ovf", 32'(ovf), 32'd0);
        m_cnt = '0; m_tc = 1'b0; m_ovf = 1'b0; m_match = 1'b0;
        @(posedge ck); #1;
        rn = 1'b1;
        lim = 4'd5; up = 1'b1;
        tick("resume");
        check_val("resume.abs", 32'(cnt), 32'd1);

        // Randomised mix
        for (int i = 0; i < 60; i++) begin
            clr     = ($urandom_range(0, 15) == 0);
            load    = ($urandom_range(0, 7) == 0);
            val     = N'($urandom);
            en      = ($urandom_range(0, 3) != 0);
            up      = $urandom_range(0, 1) == 1;
            sat     = $urandom_range(0, 1) == 1;
            lim     = (i % 10 == 0) ? N'($urandom) : lim;
            ovf_clr = ($urandom_range(0, 5) == 0);
            tick("random");
        end

`ifdef LOADUPDOWNMODCOUNT_CMP_EN
        idle_inputs(); clr = 1'b1; tick("cmp_clr");
        idle_inputs(); lim = 4'd7; sat = 1'b0; up = 1'b1; en = 1'b1; cmp = 4'd4;
        for (int i = 0; i < 8; i++) tick("cmp4");
        cmp = 4'd6;
        for (int i = 0; i < 8; i++) tick("cmp6");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
